// File: rtl/restador_serial.sv
// restador_serial: bit-serial subtractor computing D = A - B - Bin, one bit per
// clock, LSB first. The result is valid WIDTH cycles after start is accepted.
// Optional feature: define RESTADOR_OVF_EN to generate the two's-complement
// overflow flag V. When it is undefined, V is tied to 0.
module restador_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             last_bit;

`ifdef RESTADOR_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // One full-subtractor bit slice on the current LSBs.
    assign d_bit    = a_sr[0] ^ b_sr[0] ^ br;
    assign br_nxt   = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br) | (b_sr[0] & br);
    assign res_nxt  = {d_bit, res_sr[WIDTH-1:1]};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Control FSM, datapath shift registers and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            D      <= '0;
            Bout   <= 1'b0;
`ifdef RESTADOR_OVF_EN
            V      <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        br     <= Bin;
                        res_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
`ifdef RESTADOR_OVF_EN
                        a_msb  <= A[WIDTH-1];
                        b_msb  <= B[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_nxt;
                    res_sr <= res_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        D     <= res_nxt;
                        Bout  <= br_nxt;
`ifdef RESTADOR_OVF_EN
                        V     <= (a_msb ^ b_msb) & (a_msb ^ res_nxt[WIDTH-1]);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef RESTADOR_OVF_EN
    // Overflow detection disabled: the port stays, driven low.
    assign V = 1'b0;
`endif

endmodule

// File: tb/tb_restador_serial.sv
// Testbench for restador_serial: a cycle-level reference model built from
// plain arithmetic is compared against the DUT outputs on every clock, plus
// directed operations with hand-computed results.
module tb_restador_serial;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bout;
    logic         V;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    restador_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout),
        .V     (V)
    );

    always #5 clk = ~clk;

    // Expected {V, Bout, D} for one subtraction, from plain arithmetic.
    function automatic logic [W+1:0] expect_of(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic bin);
        logic [W:0] r;
        logic       v;
        r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
`ifdef RESTADOR_OVF_EN
        v = (a[W-1] ^ b[W-1]) & (a[W-1] ^ r[W-1]);
`else
        v = 1'b0;
`endif
        return {v, r};
    endfunction

    // Reference model: countdown of remaining bit cycles plus latched operands.
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_d = '0;
    logic         m_bout = 1'b0;
    logic         m_v = 1'b0;
    logic [W-1:0] m_a, m_b;
    logic         m_bin;
    logic [W+1:0] m_e;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_d    = '0;
            m_bout = 1'b0;
            m_v    = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            m_done = (m_left == 0);
            if (m_left == 0) begin
                m_e    = expect_of(m_a, m_b, m_bin);
                m_d    = m_e[W-1:0];
                m_bout = m_e[W];
                m_v    = m_e[W+1];
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_a    = A;
                m_b    = B;
                m_bin  = Bin;
                m_left = W;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_left > 0));
            check("done", 32'(done), 32'(m_done));
            check("D",    32'(D),    32'(m_d));
            check("Bout", 32'(Bout), 32'(m_bout));
            check("V",    32'(V),    32'(m_v));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation, scramble inputs while it runs, wait for done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          output logic [W-1:0] rd, output logic rbout, output logic rv);
        int lat;
        bit got;
        A = a; B = b; Bin = bin; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < int'(W) + 4; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            tick();
            lat++;
            A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(W));
        rd = D; rbout = Bout; rv = V;
    endtask

    logic [W-1:0] rd;
    logic         rbout, rv;
    int           n;
    logic [W-1:0] dval;

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_D",    32'(D),    32'd0);
        check("rst_Bout", 32'(Bout), 32'd0);
        check("rst_V",    32'(V),    32'd0);

        // Basic positive difference.
        run_op(8'h05, 8'h03, 1'b0, rd, rbout, rv);
        check("d_05_03", 32'(rd), 32'h02);
        check("b_05_03", 32'(rbout), 32'd0);
        check("v_05_03", 32'(rv), 32'd0);

        // Negative result wraps with borrow-out; borrow-in alone.
        run_op(8'h03, 8'h05, 1'b0, rd, rbout, rv);
        check("d_03_05", 32'(rd), 32'hFE);
        check("b_03_05", 32'(rbout), 32'd1);
        run_op(8'h00, 8'h00, 1'b1, rd, rbout, rv);
        check("d_00_00_1", 32'(rd), 32'hFF);
        check("b_00_00_1", 32'(rbout), 32'd1);

        // Signed overflow case.
        run_op(8'h80, 8'h01, 1'b0, rd, rbout, rv);
        check("d_80_01", 32'(rd), 32'h7F);
        check("b_80_01", 32'(rbout), 32'd0);
`ifdef RESTADOR_OVF_EN
        check("v_80_01", 32'(rv), 32'd1);
`else
        check("v_80_01", 32'(rv), 32'd0);
`endif
        tick();

        // Start while busy must be ignored.
        A = 8'h10; B = 8'h01; Bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        A = 8'hFF; B = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        dval = '0;
        for (int i = 0; i < 2 * int'(W); i++) begin
            @(negedge clk);
            if (done) begin
                n++;
                dval = D;
            end
            tick();
        end
        check("busy_start_pulses", 32'(n), 32'd1);
        check("busy_start_D", 32'(dval), 32'h0F);

        // Start held high: back-to-back operations, one done per W+1 cycles.
        A = W'($urandom); B = W'($urandom); Bin = 1'($urandom); start = 1'b1;
        n = 0;
        for (int i = 0; i < 3 * (int'(W) + 1); i++) begin
            tick();
            A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
            @(negedge clk);
            if (done) n++;
        end
        start = 1'b0;
        check("b2b_pulses", 32'(n), 32'd3);
        tick();
        tick();

        // Known nonzero result, then reset in the 4th SHIFT cycle.
        run_op(8'h55, 8'h22, 1'b0, rd, rbout, rv);
        check("d_55_22", 32'(rd), 32'h33);
        tick();
        A = 8'hF0; B = 8'h0F; Bin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_D",    32'(D),    32'd0);
        check("abort_Bout", 32'(Bout), 32'd0);
        check("abort_V",    32'(V),    32'd0);
        n = 0;
        for (int i = 0; i < int'(W) + 4; i++) begin
            tick();
            @(negedge clk);
            if (done) n++;
        end
        check("abort_no_done", 32'(n), 32'd0);

        // First start after reset is accepted normally.
        run_op(8'h20, 8'h01, 1'b1, rd, rbout, rv);
        check("d_20_01_1", 32'(rd), 32'h1E);
        check("b_20_01_1", 32'(rbout), 32'd0);

        // Randomized operations with random idle gaps.
        for (int t = 0; t < 40; t++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), rd, rbout, rv);
            repeat ($urandom_range(0, 3)) tick();
        end

        tick();
        tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/restador_serial.md
RESTADOR_SERIAL -- requirements
Module: restador_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port start, input, 1 bit: request to begin a subtraction, sampled each clk edge.
REQ-005 The block SHALL have the ports A and B, input, WIDTH bits each: minuend and subtrahend, sampled only on an accepted start.
REQ-006 The block SHALL have the port Bin, input, 1 bit: borrow-in, sampled only on an accepted start.
REQ-007 The block SHALL have the port busy, output, 1 bit: high while the bit-serial operation is in progress.
REQ-008 The block SHALL have the port done, output, 1 bit: single-cycle pulse marking the result valid.
REQ-009 The block SHALL have the port D, output, WIDTH bits: difference A - B - Bin, modulo 2^WIDTH.
REQ-010 The block SHALL have the port Bout, output, 1 bit: final borrow-out, 1 when A < B + Bin treated as unsigned.
REQ-011 The block SHALL have the port V, output, 1 bit: two's-complement overflow flag (see Configuration).

Function
REQ-012 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-013 In IDLE or DONE with start=1, the block SHALL latch A, B and Bin into internal shift/borrow registers, clear the bit counter, and enter SHIFT.
REQ-014 Each cycle in SHIFT, the block SHALL process one bit, LSB first: d = a ^ b ^ br; br_next = (~a & b) | (~a & br) | (b & br).
REQ-015 Each difference bit SHALL shift into the result register from the MSB side, so that after WIDTH cycles bit i of the result equals result bit i.
REQ-016 After exactly WIDTH SHIFT cycles, the block SHALL enter DONE, update D and Bout (and V), and assert done for exactly that one cycle.
REQ-017 Latency: with start accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-018 busy SHALL be high exactly during SHIFT cycles and low in IDLE and DONE.
REQ-019 DONE SHALL return to IDLE on the next edge unless start=1, in which case it enters SHIFT (back-to-back operation, no dead cycle).
REQ-020 start SHALL be ignored while busy=1; the operands of the in-flight operation SHALL be unaffected by changes on A, B and Bin.
REQ-021 D, Bout and V SHALL hold their last result until the next DONE, including while a new operation is in SHIFT.

Reset
REQ-022 rst=1 at a clk edge SHALL force IDLE and clear D, Bout, V, busy, done, the counter, the shift registers and the borrow register to 0.
REQ-023 rst SHALL take priority over start and SHALL abort an in-progress operation with no done pulse.
REQ-024 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-025 Macro RESTADOR_OVF_EN defined: V SHALL be updated at DONE as (A[MSB] ^ B[MSB]) & (A[MSB] ^ D[MSB]) of the latched operands.
REQ-026 Macro RESTADOR_OVF_EN undefined: V SHALL be held constant 0, with no overflow logic synthesized; the port SHALL still exist.

Verification
REQ-027 The bench SHALL cover this case (WIDTH=8): A=0x05, B=0x03, Bin=0, start pulse -> done 9 cycles later, D=0x02, Bout=0, V=0.
REQ-028 The bench SHALL cover this case: A=0x03, B=0x05, Bin=0 -> D=0xFE, Bout=1; then A=0x00, B=0x00, Bin=1 -> D=0xFF, Bout=1.
REQ-029 The bench SHALL cover this case: A=0x80, B=0x01, Bin=0 -> D=0x7F, Bout=0, V=1 with RESTADOR_OVF_EN defined, V=0 without it.
REQ-030 The bench SHALL cover this case: start with A=0x10, B=0x01, then start with A=0xFF, B=0xFF 3 cycles later while busy -> second start ignored, D=0x0F, single done pulse.
REQ-031 The bench SHALL cover this case: start held high continuously -> done every 9 cycles, busy low only during the DONE cycle, each D matches the operands sampled at that DONE/IDLE edge.
REQ-032 The bench SHALL cover this case: rst=1 at cycle 4 of SHIFT -> next cycle busy=0, done=0, D=0x00, Bout=0, V=0, and no done pulse follows.
